// File: rtl/imem_dmem_arbiter.sv
// Purpose : shares one single-port memory between instruction fetch and data access,
//           data first, with fetch anti-starvation and a bus-timeout watchdog.
// Latency : 3 cycles minimum per access (IDLE grant, BUSY with mem_rdy, DONE ack);
//           requesters hold req until their one-cycle ack, memory may stall BUSY for
//           up to TIMEOUT+1 cycles before the access is aborted with bus_err.
// Ports   : clock/reset (sync, active-high); i_req/i_addr -> i_rdata/i_ack (fetch);
//           d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack (load/store); bus_err with a
//           timed-out ack; stall_if/stall_mem for pipeline registers; mem_* to memory.
module imem_dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner_d;     // 1 = current access belongs to data port
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          err;

  logic grant_data;
  logic streak_full;
  logic timeout_hit;

  assign streak_full = (streak == SW'(STARVE_MAX));
  assign timeout_hit = (tcnt == TW'(TIMEOUT));
  // Data wins ties unless fetch has already been passed over STARVE_MAX times in a row.
  assign grant_data  = d_req && !(i_req && streak_full);

  // Stall path is deliberately just req and ack.
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = BUSY;
      BUSY:    if (mem_rdy || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    bus_err   = 1'b0;
    if (state == BUSY) begin
      mem_req   = 1'b1;
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
    if (state == DONE) begin
      i_ack   = ~owner_d;
      d_ack   = owner_d;
      bus_err = err;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      streak    <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= grant_data;
            tcnt    <= '0;
            err     <= 1'b0;
            if (grant_data) begin
              lat_we    <= d_we;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
              // Streak only grows while fetch is actually waiting.
              if (i_req) begin
                if (!streak_full) streak <= streak + 1'b1;
              end else begin
                streak <= '0;
              end
            end else begin
              lat_we    <= 1'b0;
              lat_addr  <= i_addr;
              lat_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            // Stores complete without touching the load data register.
            if (!lat_we) begin
              if (owner_d) d_rdata <= mem_rdata;
              else         i_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            if (owner_d) d_rdata <= '0;
            else         i_rdata <= '0;
            err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios with literal expectations, then
// random requesters and a random-latency memory, all compared every cycle against
// a transaction-level reference of the arbitration rules.
module tb_imem_dmem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  imem_dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_in_mem;     // a transaction is occupying the memory
  bit          m_ack_cyc;    // this cycle reports completion
  bit          m_own_d;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  int          m_age, m_streak;
  bit          m_err;

  always @(posedge clock) begin
    if (reset) begin
      m_in_mem = 0; m_ack_cyc = 0; m_own_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_ir = 0; m_dr = 0; m_age = 0; m_streak = 0; m_err = 0;
    end else if (m_ack_cyc) begin
      m_ack_cyc = 0;
    end else if (m_in_mem) begin
      if (mem_rdy) begin
        if (!m_we) begin
          if (m_own_d) m_dr = rd_fn(m_addr); else m_ir = rd_fn(m_addr);
        end
        m_in_mem = 0; m_ack_cyc = 1;
      end else if (m_age == TIMEOUT) begin
        if (m_own_d) m_dr = 0; else m_ir = 0;
        m_err = 1; m_in_mem = 0; m_ack_cyc = 1;
      end else begin
        m_age++;
      end
    end else if (i_req || d_req) begin
      m_own_d = d_req && !(i_req && m_streak == STARVE_MAX);
      if (m_own_d) begin
        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = i_req ? ((m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1) : 0;
      end else begin
        m_we = 0; m_addr = i_addr; m_wdata = 0; m_streak = 0;
      end
      m_in_mem = 1; m_age = 0; m_err = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("mem_req", mem_req, m_in_mem);
      chk("mem_we", mem_we, m_in_mem && m_we);
      chk("mem_addr", mem_addr, m_in_mem ? m_addr : 32'h0);
      chk("mem_wdata", mem_wdata, m_in_mem ? m_wdata : 32'h0);
      chk("i_ack", i_ack, m_ack_cyc && !m_own_d);
      chk("d_ack", d_ack, m_ack_cyc && m_own_d);
      chk("bus_err", bus_err, m_ack_cyc && m_err);
      chk("i_rdata", i_rdata, m_ir);
      chk("d_rdata", d_rdata, m_dr);
      chk("stall_if", stall_if, i_req && !(m_ack_cyc && !m_own_d));
      chk("stall_mem", stall_mem, d_req && !(m_ack_cyc && m_own_d));
    end
  end

  // ---------------- memory responder ----------------
  bit rnd_mode = 0;
  bit never = 0;
  int lat_fix = 0;

  initial begin
    int cnt, tgt;
    bit nv;
    cnt = 0; tgt = 0; nv = 0;
    mem_rdy = 0; mem_rdata = 0;
    forever begin
      @(posedge clock); #1;
      if (!mem_req) begin
        cnt = 0;
        mem_rdy = rnd_mode && ($urandom % 4 == 0);   // ignored outside BUSY
        mem_rdata = $urandom;
      end else begin
        if (cnt == 0) begin
          if (rnd_mode) begin tgt = $urandom_range(0, 5); nv = ($urandom % 40 == 0); end
          else begin tgt = lat_fix; nv = never; end
        end
        if (!nv && cnt == tgt) begin mem_rdy = 1; mem_rdata = rd_fn(mem_addr); end
        else begin mem_rdy = 0; mem_rdata = $urandom; end
        cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1; i_req = 0; d_req = 0;
    repeat (2) @(posedge clock);
    #2 reset = 0;
  endtask

  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input bit nv,
                        output int busy_n, output logic [31:0] rd, output logic err,
                        output bit stable, output bit got, output logic stall_at_ack);
    @(posedge clock); #2;
    lat_fix = lat; never = nv;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else begin i_req = 1; i_addr = addr; end
    busy_n = 0; stable = 1; got = 0; rd = 'x; err = 'x; stall_at_ack = 'x;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clock);
      if (mem_req) begin
        busy_n++;
        if (mem_addr !== addr || mem_we !== we) stable = 0;
      end
      if (is_d ? d_ack : i_ack) begin
        got = 1; rd = is_d ? d_rdata : i_rdata; err = bus_err;
        stall_at_ack = is_d ? stall_mem : stall_if;
      end
      // Changes to the held address while busy must be ignored.
      if (mem_req && !got) begin
        if (is_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~we; end
        else i_addr = $urandom;
      end
      #1;
      if (is_d) begin d_addr = addr; d_we = we; d_wdata = wd; end else i_addr = addr;
    end
    @(posedge clock); #2;
    i_req = 0; d_req = 0; never = 0;
  endtask

  initial begin
    int bn;
    logic [31:0] rd, ord [8];
    logic er, st_ack, dr_before;
    bit stab, got, prev_req, ia, da, ddone, idone, stall_bad, first_we;
    int ngr, ndata_first;
    logic [31:0] d_before;

    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    dr_before = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_acks", {i_ack, d_ack, bus_err, mem_we, stall_if, stall_mem}, 0);
    @(posedge clock); #2 reset = 0;
    chk_on = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("idle_mem_req", mem_req, 0);
    end

    // Fetch only, memory answers in the third BUSY cycle.
    access(0, 0, 32'h40, 0, 2, 0, bn, rd, er, stab, got, st_ack);
    chk("fetch_ack_seen", got, 1);
    chk("fetch_busy_cycles", bn, 3);
    chk("fetch_addr_we_stable", stab, 1);
    chk("fetch_rdata", rd, 32'h8C010004);
    chk("fetch_stall_at_ack", st_ack, 0);
    chk("fetch_err", er, 0);
    @(negedge clock);
    chk("fetch_ack_one_cycle", i_ack, 0);

    // Load so d_rdata holds something a store must not disturb.
    access(1, 0, 32'h8, 0, 0, 0, bn, rd, er, stab, got, st_ack);
    chk("load_rdata", rd, rd_fn(32'h8));
    d_before = rd_fn(32'h8);

    // Simultaneous fetch and store: data first.
    lat_fix = 0;
    @(posedge clock); #2;
    i_req = 1; i_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    ngr = 0; prev_req = 0; ddone = 0; idone = 0; stall_bad = 0; first_we = 0;
    for (int k = 0; k < 30 && !(ddone && idone); k++) begin
      @(negedge clock);
      ia = i_ack; da = d_ack;
      if (mem_req && !prev_req && ngr < 8) begin
        if (ngr == 0) first_we = mem_we;
        ord[ngr] = mem_addr; ngr++;
      end
      prev_req = mem_req;
      if (!ddone && !stall_if) stall_bad = 1;
      if (da) begin ddone = 1; chk("sim_d_rdata_kept", d_rdata, d_before); chk("sim_d_before_i", idone, 0); end
      if (ia) idone = 1;
      @(posedge clock); #2;
      if (da) d_req = 0;
      if (ia) i_req = 0;
    end
    chk("sim_both_done", {ddone, idone}, 2'b11);
    chk("sim_first_addr", ord[0], 32'h100);
    chk("sim_first_we", first_we, 1);
    chk("sim_second_addr", ord[1], 32'h80);
    chk("sim_stall_if_held", stall_bad, 0);

    // Starvation: loads back to back with fetch waiting.
    do_reset();
    lat_fix = 0;
    @(posedge clock); #2;
    i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
    ngr = 0; prev_req = 0;
    for (int k = 0; k < 80 && (i_req || d_req); k++) begin
      @(negedge clock);
      ia = i_ack; da = d_ack;
      if (mem_req && !prev_req && ngr < 8) begin ord[ngr] = mem_addr; ngr++; end
      prev_req = mem_req;
      @(posedge clock); #2;
      if (ia) i_req = 0;
      if (da) begin
        if (ngr >= 6) d_req = 0;
        else d_addr = 32'h300 + 32'(4 * ngr);
      end
    end
    chk("starve_grants", ngr, 6);
    ndata_first = 0;
    for (int k = 0; k < 4; k++) if (ord[k] >= 32'h300) ndata_first++;
    chk("starve_data_first4", ndata_first, 4);
    chk("starve_fetch_5th", ord[4], 32'h200);
    chk("starve_data_6th", ord[5] >= 32'h300, 1);

    // Timeout on a fetch, then the next access clears err.
    access(0, 0, 32'h40, 0, 0, 0, bn, rd, er, stab, got, st_ack);
    chk("pre_tmo_rdata", rd, 32'h8C010004);
    access(0, 0, 32'h44, 0, 0, 1, bn, rd, er, stab, got, st_ack);
    chk("tmo_ack_seen", got, 1);
    chk("tmo_busy_cycles", bn, 256);
    chk("tmo_bus_err", er, 1);
    chk("tmo_rdata", rd, 0);
    access(1, 0, 32'h20, 0, 1, 0, bn, rd, er, stab, got, st_ack);
    chk("tmo_clear_err", er, 0);
    chk("tmo_next_rdata", rd, rd_fn(32'h20));

    // Reset on the third BUSY cycle of a stalled fetch.
    access(0, 0, 32'h40, 0, 0, 0, bn, rd, er, stab, got, st_ack);
    never = 1;
    @(posedge clock); #2;
    i_req = 1; i_addr = 32'h24;
    bn = 0;
    for (int k = 0; k < 20 && bn < 3; k++) begin
      @(negedge clock);
      if (mem_req) bn++;
    end
    chk("rst_mid_reached_busy3", bn, 3);
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_acks", {i_ack, d_ack, bus_err}, 0);
    chk("rst_mid_i_rdata", i_rdata, 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    @(posedge clock); #2;
    reset = 0; i_req = 0; never = 0;
    repeat (3) @(posedge clock);

    // Random traffic against the model.
    rnd_mode = 1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      ia = i_ack; da = d_ack;
      @(posedge clock); #2;
      reset = ($urandom % 700 == 0);
      if (ia || !i_req) begin
        i_req = ($urandom % 3 != 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end else begin
        if ($urandom % 50 == 0) i_req = 0;
        if ($urandom % 8 == 0) i_addr = $urandom;
      end
      if (da || !d_req) begin
        d_req = ($urandom % 2 == 0);
        d_we = $urandom; d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end else begin
        if ($urandom % 50 == 0) d_req = 0;
        if ($urandom % 8 == 0) begin d_addr = $urandom; d_we = $urandom; d_wdata = $urandom; end
      end
    end
    @(posedge clock); #2;
    reset = 0; i_req = 0; d_req = 0;
    repeat (300) @(posedge clock);
    @(negedge clock);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
